// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an 8-deep FIFO and sends them LSB-first as start/8 data/stop frames.
// Optional even-parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_POP, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_POP, S_WAIT, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_idx, w_idx;
  logic [7:0]    r_shift, w_shift;
  logic          r_tx, w_tx;
  logic          r_rd, r_busy, r_done;
  logic          w_last;

  // Next-state values; tx is produced from the next state so the line is registered.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + CW'(1);
    w_idx   = r_idx;
    w_shift = r_shift;
    w_tx    = r_tx;
    w_last  = (r_cnt == LAST);
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        w_tx  = 1'b1;
        if (!fifo_empty) w_state = S_POP;
      end
      S_POP: begin
        w_cnt   = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        w_cnt   = '0;
        w_shift = fifo_data;
        w_state = S_START;
        w_tx    = 1'b0;
      end
      S_START: begin
        if (w_last) begin
          w_cnt   = '0;
          w_idx   = '0;
          w_state = S_DATA;
          w_tx    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt = '0;
          if (r_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_state = S_PARITY;
            w_tx    = ^r_shift;
`else
            w_state = S_STOP;
            w_tx    = 1'b1;
`endif
          end else begin
            w_idx = r_idx + 3'd1;
            w_tx  = r_shift[w_idx];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_last) begin
          w_cnt   = '0;
          w_state = S_STOP;
          w_tx    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_last) begin
          w_cnt   = '0;
          w_state = S_IDLE;
          w_tx    = 1'b1;
        end
      end
      default: begin
        w_cnt   = '0;
        w_state = S_IDLE;
        w_tx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_rd    <= (w_state == S_POP);
      r_busy  <= (w_state != S_IDLE);
      r_done  <= (w_state == S_STOP) && (w_cnt == LAST);
    end
  end

  assign fifo_rd    = r_rd;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a behavioural FIFO and an expected-byte scoreboard.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic       fake_ne = 1'b0;
  int         rd_cnt = 0;
  int         total = 0;
  int         bad = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: pop on the read strobe, data valid the following cycle.
  always @(negedge clk) begin
    if (fifo_rd === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      if (fq.size() > 0) fifo_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0) && !fake_ne;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Collects one frame from the line, sampled at negedges; does not judge it.
  task automatic rx_frame(output logic [7:0] d, output logic st, output logic par,
                          output logic sp, output logic stable, output int done_at,
                          output int ndone, output int gap, output logic tmo);
    logic bits [0:10];
    tmo = 1'b1; stable = 1'b1; done_at = -1; ndone = 0; gap = 0;
    d = '0; st = 1'b1; par = 1'b0; sp = 1'b0;
    for (int i = 0; i < 11; i++) bits[i] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin tmo = 1'b0; break; end
      gap++;
    end
    if (tmo) return;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) stable = 1'b0;
        if (frame_done === 1'b1) begin ndone++; done_at = b * CPB + c; end
      end
    end
    st = bits[0];
    for (int j = 0; j < 8; j++) d[j] = bits[j + 1];
    par = bits[9];
    sp  = bits[NB - 1];
  endtask

  task automatic test_reset;
    int viol;
    viol = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (fifo_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b want=0", fifo_rd); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL idle_empty violations got=%0d want=0", viol); end
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL idle_empty rd_count got=%0d want=0", rd_cnt); end
  endtask

  task automatic test_single(input logic [7:0] b, input logic exp_par);
    logic [7:0] d, e;
    logic st, par, sp, stable, tmo;
    int done_at, ndone, gap, rd0;
    rd0 = rd_cnt;
    fq.push_back(b); exp_q.push_back(b);
    rx_frame(d, st, par, sp, stable, done_at, ndone, gap, tmo);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL single_timeout byte=%h got=%b want=0", b, tmo); end
    total++; if (d !== e) begin bad++; $display("FAIL single_data got=%h want=%h", d, e); end
    total++; if (st !== 1'b0) begin bad++; $display("FAIL single_start got=%b want=0", st); end
    total++; if (sp !== 1'b1) begin bad++; $display("FAIL single_stop got=%b want=1", sp); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL single_bit_width byte=%h got=%b want=1", b, stable); end
    total++; if (ndone !== 1 || done_at !== NB * CPB - 1) begin
      bad++; $display("FAIL single_frame_done pulses=%0d at=%0d want 1 at %0d", ndone, done_at, NB * CPB - 1);
    end
`ifdef FIFO_UART_TX_PARITY_EN
    total++; if (par !== exp_par) begin bad++; $display("FAIL single_parity byte=%h got=%b want=%b", b, par, exp_par); end
`endif
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    total++; if (rd_cnt - rd0 !== 1) begin bad++; $display("FAIL single_rd_pulses got=%0d want=1", rd_cnt - rd0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d, e;
    logic st, par, sp, stable, tmo;
    int done_at, ndone, gap, rd0, viol;
    rd0 = rd_cnt; viol = 0;
    fq.push_back(8'h0A); fq.push_back(8'h0B); fq.push_back(8'h0C);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h0B); exp_q.push_back(8'h0C);
    for (int f = 0; f < 3; f++) begin
      rx_frame(d, st, par, sp, stable, done_at, ndone, gap, tmo);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total++; if (d !== e || tmo !== 1'b0) begin bad++; $display("FAIL b2b_data frame=%0d got=%h want=%h tmo=%b", f, d, e, tmo); end
      total++; if (sp !== 1'b1 || stable !== 1'b1 || done_at !== NB * CPB - 1) begin
        bad++; $display("FAIL b2b_frame frame=%0d stop=%b stable=%b done_at=%0d", f, sp, stable, done_at);
      end
      if (f > 0) begin
        total++; if (gap !== 3) begin bad++; $display("FAIL b2b_gap frame=%0d got=%0d want=3", f, gap); end
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_fall got=%b want=0", busy); end
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL b2b_idle violations got=%0d want=0", viol); end
    total++; if (rd_cnt - rd0 !== 3) begin bad++; $display("FAIL b2b_rd_pulses got=%0d want=3", rd_cnt - rd0); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d, e;
    logic st, par, sp, stable, tmo;
    int done_at, ndone, gap, rd0, viol, w;
    rd0 = rd_cnt; viol = 0; w = 0;
    fq.push_back(8'h0B); fq.push_back(8'h0C);
    exp_q.push_back(8'h0C);
    while (tx !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midrst_start_seen got=%b want=0", tx); end
    repeat (21) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx_async got=%b want=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    total++; if (fifo_rd !== 1'b1) begin bad++; $display("FAIL midrst_first_pop got=%b want=1", fifo_rd); end
    rx_frame(d, st, par, sp, stable, done_at, ndone, gap, tmo);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total++; if (d !== e || tmo !== 1'b0) begin bad++; $display("FAIL midrst_next_data got=%h want=%h tmo=%b", d, e, tmo); end
    total++; if (sp !== 1'b1 || stable !== 1'b1 || done_at !== NB * CPB - 1) begin
      bad++; $display("FAIL midrst_frame stop=%b stable=%b done_at=%0d", sp, stable, done_at);
    end
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL midrst_no_resend violations got=%0d want=0", viol); end
    total++; if (rd_cnt - rd0 !== 2) begin bad++; $display("FAIL midrst_rd_pulses got=%0d want=2", rd_cnt - rd0); end
  endtask

  task automatic test_empty_toggle;
    logic [7:0] d, e;
    logic st, par, sp, stable, tmo;
    int done_at, ndone, gap, rd0;
    rd0 = rd_cnt;
    fq.push_back(8'h3C); exp_q.push_back(8'h3C);
    fork
      rx_frame(d, st, par, sp, stable, done_at, ndone, gap, tmo);
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (tx === 1'b0) break;
        end
        repeat (30) begin
          @(negedge clk);
          fake_ne = 1'($urandom_range(0, 1));
        end
        fake_ne = 1'b0;
      end
    join
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total++; if (d !== e || tmo !== 1'b0) begin bad++; $display("FAIL toggle_data got=%h want=%h tmo=%b", d, e, tmo); end
    total++; if (stable !== 1'b1 || ndone !== 1 || done_at !== NB * CPB - 1) begin
      bad++; $display("FAIL toggle_timing stable=%b pulses=%0d done_at=%0d", stable, ndone, done_at);
    end
    repeat (10) @(negedge clk);
    total++; if (rd_cnt - rd0 !== 1) begin bad++; $display("FAIL toggle_rd_pulses got=%0d want=1", rd_cnt - rd0); end
    total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL toggle_idle busy=%b tx=%b want 0/1", busy, tx); end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, 1'b0);
    test_single(8'h01, 1'b1);
    test_back_to_back();
    test_reset_midframe();
    test_empty_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
